// File: rtl/apb_bridge_controller.sv
// -----------------------------------------------------------------------------
// apb_bridge_controller
//
// Sequencing FSM of the AHB-to-APB bridge. Each accepted AHB transfer becomes
// a two-phase APB transfer (SETUP, then ENABLE). The AHB side is stalled
// through hready_out until the APB transfer completes. All APB outputs come
// straight from flops, so peripherals never see combinational glitches.
//
// Optional feature macro: APB_PREADY_EN
//   defined   : ENABLE is extended until pready=1 (no timeout).
//   undefined : pready is ignored and ENABLE always lasts exactly one cycle.
//
// Ports
//   hclk        in   bridge clock, rising edge
//   hresetn     in   asynchronous active-low reset
//   valid       in   current AHB address phase is a legal bridge transfer
//   hwrite      in   direction of the current address phase
//   haddr       in   current address-phase address
//   haddr1      in   address delayed one cycle (address of the write whose
//                    data is now on hwdata)
//   hwdata      in   AHB write data (data phase)
//   temp_sel    in   decoded peripheral select for haddr
//   pready      in   APB completion (used only with APB_PREADY_EN)
//   psel        out  APB select, registered
//   penable     out  APB enable, registered
//   pwrite      out  APB direction, registered
//   paddr       out  APB address, registered
//   pwdata      out  APB write data, registered
//   hready_out  out  AHB ready, combinational from state (and pready)
//   busy        out  FSM is not idle
// -----------------------------------------------------------------------------
module apb_bridge_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 3
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              valid,
   input  logic              hwrite,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [ADDR_W-1:0] haddr1,
   input  logic [DATA_W-1:0] hwdata,
   input  logic [SEL_W-1:0]  temp_sel,
   input  logic              pready,
   output logic [SEL_W-1:0]  psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              hready_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WWAIT  = 2'b01,
      SETUP  = 2'b10,
      ENABLE = 2'b11
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] sel_q;   // select of an accepted write, used once hwdata arrives
   logic             done;    // APB transfer completes this cycle (ENABLE only)

`ifdef APB_PREADY_EN
   assign done = pready;
`else
   // pready stays on the port for a uniform interface but has no effect here.
   logic unused_pready;
   assign unused_pready = pready;
   assign done          = 1'b1;
`endif

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      hready_out = 1'b1;
      case (state)
         IDLE:    hready_out = 1'b1;
         WWAIT:   hready_out = 1'b0;
         SETUP:   hready_out = 1'b0;
         ENABLE:  hready_out = done;
         default: hready_out = 1'b1;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         // NOTE: the async reset clears the APB outputs immediately, so an
         // interrupted transfer is dropped without a completion phase.
         state   <= IDLE;
         sel_q   <= '0;
         psel    <= '0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  sel_q <= temp_sel;
                  if (!hwrite) begin
                     state  <= SETUP;
                     paddr  <= haddr;
                     psel   <= temp_sel;
                     pwrite <= 1'b0;
                  end else begin
                     // Write data arrives one cycle later; wait for it.
                     state <= WWAIT;
                  end
               end
            end

            WWAIT: begin
               state  <= SETUP;
               paddr  <= haddr1;
               pwdata <= hwdata;
               psel   <= sel_q;
               pwrite <= 1'b1;
            end

            SETUP: begin
               state   <= ENABLE;
               penable <= 1'b1;
            end

            ENABLE: begin
               // While !done every APB output simply holds its value.
               if (done) begin
                  penable <= 1'b0;
                  if (valid && !hwrite) begin
                     // Back-to-back read goes straight to SETUP.
                     state  <= SETUP;
                     sel_q  <= temp_sel;
                     paddr  <= haddr;
                     psel   <= temp_sel;
                     pwrite <= 1'b0;
                  end else if (valid) begin
                     state <= WWAIT;
                     sel_q <= temp_sel;
                     psel  <= '0;
                  end else begin
                     state  <= IDLE;
                     psel   <= '0;
                     pwrite <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
